spi_slave_frontend: RTL and testbench

- Upstream stage of the dual-port RAM: turns an SPI (mode 0) frame stream into single-cycle RAM write/read requests on one RAM port.
- Returns read data serially on miso.
- SPI pins are oversampled in the clk domain; no second clock.
- Frame: 2-bit command followed by ADDR_SIZE payload bits, MSB first.

---
 rtl/spi_slave_frontend_if.sv | 32 +++
 rtl/spi_slave_frontend.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_slave_frontend.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_frontend_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_frontend_if
// Brief    : SPI pin bundle plus the single RAM port driven by the frontend.
// Revision : 1.0
// ============================================================================
interface spi_slave_frontend_if #(
  parameter int ADDR_SIZE = 8
) ();
  logic                 sclk;
  logic                 mosi;
  logic                 ss_n;
  logic                 miso;
  logic [ADDR_SIZE-1:0] addr;
  logic [ADDR_SIZE-1:0] din;
  logic                 rx_en;
  logic                 tx_en;
  logic [ADDR_SIZE-1:0] dout;
  logic                 tx_valid;
  logic                 frame_err;

  modport slave (
    input  sclk, mosi, ss_n, dout, tx_valid,
    output miso, addr, din, rx_en, tx_en, frame_err
  );

  modport master (
    output sclk, mosi, ss_n, dout, tx_valid,
    input  miso, addr, din, rx_en, tx_en, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_frontend.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_frontend
// Brief    : Oversampled SPI mode-0 slave that turns frames into RAM requests.
// Revision : 1.0
// ============================================================================
module spi_slave_frontend #(
  parameter int ADDR_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_slave_frontend_if.slave bus
);

  localparam int FRAME_BITS = ADDR_SIZE + 2;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int FLUSH_W    = $clog2(SYNC_STAGES + 1);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [CNT_W-1:0] LAST_RX_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_TX_BIT = CNT_W'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    EXEC     = 3'd2,
    WAIT_TX  = 3'd3,
    SEND     = 3'd4,
    WAIT_END = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q,   ss_prev_d;
  logic [FLUSH_W-1:0]     flush_q,     flush_d;
  logic                   armed_q,     armed_d;

  state_t                 state_q,     state_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [FRAME_BITS-1:0]  shift_q,     shift_d;
  logic [ADDR_SIZE-1:0]   tx_q,        tx_d;
  logic [ADDR_SIZE-1:0]   wr_addr_q,   wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q,   rd_addr_d;
  logic [ADDR_SIZE-1:0]   addr_q,      addr_d;
  logic [ADDR_SIZE-1:0]   din_q,       din_d;
  logic                   miso_q,      miso_d;
  logic                   rx_en_q,     rx_en_d;
  logic                   tx_en_q,     tx_en_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                   flushed;
  logic [FRAME_BITS-1:0]  rx_next;
  logic [1:0]             rx_cmd, cur_cmd;
  logic [ADDR_SIZE-1:0]   rx_payload, cur_payload;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];

  // sclk activity only counts while the slave is selected
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~ss_s;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign flushed   = (flush_q == FLUSH_W'(SYNC_STAGES));

  assign rx_next     = {shift_q[FRAME_BITS-2:0], mosi_s};
  assign rx_cmd      = rx_next[FRAME_BITS-1 -: 2];
  assign rx_payload  = rx_next[ADDR_SIZE-1:0];
  assign cur_cmd     = shift_q[FRAME_BITS-1 -: 2];
  assign cur_payload = shift_q[ADDR_SIZE-1:0];

  // A frame may only start once ss_n has been seen high with the synchronizer
  // holding real pin samples, so a reset released mid-select stays idle.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   bus.ss_n};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    flush_d     = flushed ? flush_q : flush_q + FLUSH_W'(1);
    armed_d     = armed_q | (flushed & ss_s);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    addr_d      = addr_q;
    din_d       = din_q;
    miso_d      = 1'b0;
    rx_en_d     = 1'b0;
    tx_en_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end

      RECV: begin
        if (ss_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          shift_d = rx_next;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_RX_BIT) begin
            // Strobes are registered on entry so they are high during EXEC
            state_d = EXEC;
            if (rx_cmd == CMD_WR_DATA) begin
              addr_d  = wr_addr_q;
              din_d   = rx_payload;
              rx_en_d = 1'b1;
            end else if (rx_cmd == CMD_RD_DATA) begin
              addr_d  = rd_addr_q;
              tx_en_d = 1'b1;
            end
          end
        end
      end

      EXEC: begin
        if (cur_cmd == CMD_WR_ADDR) wr_addr_d = cur_payload;
        if (cur_cmd == CMD_RD_ADDR) rd_addr_d = cur_payload;
        if (ss_rise)                     state_d = IDLE;
        else if (cur_cmd == CMD_RD_DATA) state_d = WAIT_TX;
        else                             state_d = WAIT_END;
      end

      WAIT_TX: begin
        if (ss_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (bus.tx_valid) begin
          tx_d    = bus.dout;
          miso_d  = bus.dout[ADDR_SIZE-1];
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (ss_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          // The fall trailing the last command bit lands here; the MSB must
          // survive until the master has sampled it on the first rise.
          if (sclk_fall && (cnt_q != '0)) tx_d = {tx_q[ADDR_SIZE-2:0], 1'b0};
          miso_d = tx_d[ADDR_SIZE-1];
          if (sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_TX_BIT) begin
              state_d = WAIT_END;
              miso_d  = 1'b0;
            end
          end
        end
      end

      WAIT_END: begin
        if (ss_rise) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      miso_q      <= 1'b0;
      rx_en_q     <= 1'b0;
      tx_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      miso_q      <= miso_d;
      rx_en_q     <= rx_en_d;
      tx_en_q     <= tx_en_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.addr      = addr_q;
  assign bus.din       = din_q;
  assign bus.rx_en     = rx_en_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_frontend
// Brief    : Scoreboard bench: SPI master stimulus, RAM model, event monitor.
// Revision : 1.0
// ============================================================================
module tb_spi_slave_frontend;

  localparam int AW    = 8;
  localparam int HP    = 6;
  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  spi_slave_frontend_if #(.ADDR_SIZE(AW)) bus ();

  spi_slave_frontend #(.ADDR_SIZE(AW), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  ev_t        exp_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] m_wr, m_rd;
  logic [7:0] h_addr, h_din;
  bit   [7:0] ram     [256];
  bit         ram_wr  [256];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a * 8'd37) ^ 8'h5A;
  endfunction

  function automatic ev_t mk_ev(input int k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    return e;
  endfunction

  // RAM model: read data is presented one cycle after tx_en
  always @(posedge clk) begin
    bus.tx_valid <= 1'b0;
    if (bus.tx_en) begin
      bus.tx_valid <= 1'b1;
      bus.dout     <= ram_wr[bus.addr] ? ram[bus.addr] : init_val(bus.addr);
    end
    if (bus.rx_en) begin
      ram[bus.addr]    <= bus.din;
      ram_wr[bus.addr] <= 1'b1;
    end
  end

  task automatic pop_check(input int k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%h din=%h none expected", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k != K_ERR && a !== e.a) || (k == K_WR && d !== e.d)) begin
        errors++;
        $display("FAIL event actual kind=%0d addr=%h din=%h expected kind=%0d addr=%h din=%h",
                 k, a, d, e.kind, e.a, e.d);
      end
      if (e.kind == K_WR) begin h_addr = e.a; h_din = e.d; end
      if (e.kind == K_RD) h_addr = e.a;
    end
  endtask

  // Monitor: every strobe/pulse consumes one expected event
  always @(negedge clk) begin
    if (rst) begin
      h_addr = 8'h00;
      h_din  = 8'h00;
    end else begin
      checks++;
      if (bus.rx_en && bus.tx_en) begin
        errors++;
        $display("FAIL strobe_overlap rx_en=1 tx_en=1 required not both");
      end
      if (bus.rx_en)       pop_check(K_WR, bus.addr, bus.din);
      else if (bus.tx_en)  pop_check(K_RD, bus.addr, 8'h00);
      else begin
        checks++;
        if (bus.addr !== h_addr || bus.din !== h_din) begin
          errors++;
          $display("FAIL hold actual addr=%h din=%h expected addr=%h din=%h",
                   bus.addr, bus.din, h_addr, h_din);
        end
      end
      if (bus.frame_err) pop_check(K_ERR, 8'h00, 8'h00);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sclk_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mosi = 1'($urandom_range(0, 1));
      wait_clk(HP); bus.sclk = 1'b1;
      wait_clk(HP); bus.sclk = 1'b0;
    end
  endtask

  // abort_at < 0: full frame; otherwise ss_n rises after abort_at sclk rises
  task automatic spi_frame(input logic [1:0] cmd, input logic [7:0] pl, input int abort_at);
    logic [9:0] w;
    logic [7:0] rxb;
    logic [7:0] exp_rd;
    int         nrise, lim;
    bit         aborted;
    w       = {cmd, pl};
    rxb     = 8'h00;
    nrise   = (cmd == 2'b11) ? 18 : 10;
    aborted = (abort_at >= 0) && (abort_at < nrise);
    lim     = aborted ? abort_at : nrise;
    exp_rd  = ref_mem[m_rd];
    if (aborted && abort_at < 10) begin
      exp_q.push_back(mk_ev(K_ERR, 8'h00, 8'h00));
    end else begin
      case (cmd)
        2'b00: m_wr = pl;
        2'b01: begin
          exp_q.push_back(mk_ev(K_WR, m_wr, pl));
          ref_mem[m_wr] = pl;
        end
        2'b10: m_rd = pl;
        default: begin
          exp_q.push_back(mk_ev(K_RD, m_rd, 8'h00));
          if (aborted) exp_q.push_back(mk_ev(K_ERR, 8'h00, 8'h00));
        end
      endcase
    end
    bus.ss_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < lim; i++) begin
      bus.mosi = (i < 10) ? w[9-i] : 1'b0;
      wait_clk(HP); bus.sclk = 1'b1;
      if (i >= 10) rxb = {rxb[6:0], bus.miso};
      wait_clk(HP); bus.sclk = 1'b0;
    end
    wait_clk(HP);
    bus.ss_n = 1'b1;
    wait_clk(3 * HP);
    if (cmd == 2'b11 && !aborted) chk("rd_data", 32'(rxb), 32'(exp_rd));
    chk("miso_idle", 32'(bus.miso), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_miso"},      32'(bus.miso),      32'd0);
    chk({tag, "_addr"},      32'(bus.addr),      32'd0);
    chk({tag, "_din"},       32'(bus.din),       32'd0);
    chk({tag, "_rx_en"},     32'(bus.rx_en),     32'd0);
    chk({tag, "_tx_en"},     32'(bus.tx_en),     32'd0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cmd;
    logic [7:0] pl;
    int         ab;
    rst      = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.ss_n = 1'b1;
    m_wr     = 8'h00;
    m_rd     = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    wait_clk(4);
    chk_zero_outputs("reset");
    rst = 1'b0;
    wait_clk(10);

    // write then read back the same location
    spi_frame(2'b00, 8'h3C, -1);
    spi_frame(2'b01, 8'hA5, -1);
    spi_frame(2'b10, 8'h3C, -1);
    spi_frame(2'b11, 8'h00, -1);

    // independent write and read address registers
    spi_frame(2'b00, 8'h10, -1);
    spi_frame(2'b10, 8'h20, -1);
    spi_frame(2'b01, 8'h55, -1);
    spi_frame(2'b11, 8'h00, -1);

    // abort during receive, then normal frames
    spi_frame(2'b01, 8'hFF, 6);
    spi_frame(2'b00, 8'h01, -1);
    spi_frame(2'b01, 8'h77, -1);

    // abort during send, then the same read address again
    spi_frame(2'b11, 8'h00, 13);
    spi_frame(2'b11, 8'h00, -1);

    // reset in the middle of a frame with ss_n held low
    bus.ss_n = 1'b0;
    wait_clk(HP);
    sclk_bits(4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_wr = 8'h00;
    m_rd = 8'h00;
    chk_zero_outputs("midreset");
    sclk_bits(10);
    wait_clk(HP);
    bus.ss_n = 1'b1;
    wait_clk(3 * HP);
    spi_frame(2'b01, 8'h9C, -1);
    spi_frame(2'b11, 8'h00, -1);

    repeat (50) begin
      cmd = 2'($urandom_range(0, 3));
      pl  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      ab  = -1;
      if ($urandom_range(0, 7) == 0)
        ab = (cmd == 2'b11) ? int'($urandom_range(1, 17)) : int'($urandom_range(1, 9));
      spi_frame(cmd, pl, ab);
    end

    wait_clk(20);
    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
